// File: rtl/spi_controller_if.sv
// spi_controller_if: request/response handshake between a requester and the SPI controller.
//   start  requester -> controller  frame request
//   rw     requester -> controller  1=write, 0=read
//   addr   requester -> controller  7-bit register address
//   wdata  requester -> controller  8-bit write data
//   busy   controller -> requester  frame in progress (accept edge through GAP)
//   done   controller -> requester  one-cycle completion pulse
//   rdata  controller -> requester  last read result
interface spi_controller_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    modport master (output start, rw, addr, wdata, input busy, done, rdata);
    modport slave  (input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 master issuing one 16-bit {rw, addr, data} frame per request, MSB first.
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport: start/rw/addr/wdata in, busy/done/rdata out
//   cipo   in   serial data from peripheral (asynchronous, synchronised here)
//   ncs    out  chip select, active low, registered
//   sclk   out  serial clock, idle low, registered
//   copi   out  serial data to peripheral, registered
module spi_controller #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_controller_if.slave  bus,
    input  logic             cipo,
    output logic             ncs,
    output logic             sclk,
    output logic             copi
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
    state_t        state, state_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic [3:0]    bcnt, bcnt_n;
    logic          ph, ph_n;
    logic [15:0]   shreg, shreg_n;
    logic          rw_q, rw_q_n;
    logic [7:0]    rx, rx_n;
    logic [7:0]    rdata_q, rdata_n;
    logic          ncs_n, sclk_n, copi_n, done_q, done_n;
    logic          cipo_m, cipo_s;
    logic          h_wrap;
    assign h_wrap    = hcnt == H_LAST;
    assign bus.busy  = state != IDLE;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        gcnt_n  = gcnt;
        bcnt_n  = bcnt;
        ph_n    = ph;
        shreg_n = shreg;
        rw_q_n  = rw_q;
        rx_n    = rx;
        rdata_n = rdata_q;
        ncs_n   = ncs;
        sclk_n  = sclk;
        copi_n  = copi;
        done_n  = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_n = SETUP;
                shreg_n = {bus.rw, bus.addr, bus.wdata};
                rw_q_n  = bus.rw;
                hcnt_n  = '0;
                ncs_n   = 1'b0;
                sclk_n  = 1'b0;
                copi_n  = bus.rw;
            end
            SETUP: begin
                hcnt_n = h_wrap ? '0 : hcnt + 1'b1;
                if (h_wrap) begin
                    state_n = SHIFT;
                    ph_n    = 1'b0;
                    bcnt_n  = 4'd15;
                    sclk_n  = 1'b1;
                end
            end
            SHIFT: begin
                hcnt_n = h_wrap ? '0 : hcnt + 1'b1;
                if (h_wrap && !ph) begin
                    // end of high phase: sample CIPO for data bits, then fall and advance COPI
                    ph_n   = 1'b1;
                    sclk_n = 1'b0;
                    if (!bcnt[3])
                        rx_n = {rx[6:0], cipo_s};
                    if (bcnt != 4'd0) begin
                        shreg_n = {shreg[14:0], 1'b0};
                        copi_n  = shreg[14];
                    end
                end else if (h_wrap) begin
                    if (bcnt == 4'd0) begin
                        state_n = GAP;
                        gcnt_n  = '0;
                        ncs_n   = 1'b1;
                        copi_n  = 1'b0;
                    end else begin
                        bcnt_n = bcnt - 4'd1;
                        ph_n   = 1'b0;
                        sclk_n = 1'b1;
                    end
                end
            end
            GAP: begin
                gcnt_n = gcnt + 1'b1;
                if (gcnt == G_LAST) begin
                    state_n = IDLE;
                    gcnt_n  = '0;
                    done_n  = 1'b1;
                    rdata_n = rw_q ? rdata_q : rx;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hcnt    <= '0;
            gcnt    <= '0;
            bcnt    <= '0;
            ph      <= 1'b0;
            shreg   <= '0;
            rw_q    <= 1'b0;
            rx      <= '0;
            rdata_q <= '0;
            ncs     <= 1'b1;
            sclk    <= 1'b0;
            copi    <= 1'b0;
            done_q  <= 1'b0;
            cipo_m  <= 1'b0;
            cipo_s  <= 1'b0;
        end else begin
            state   <= state_n;
            hcnt    <= hcnt_n;
            gcnt    <= gcnt_n;
            bcnt    <= bcnt_n;
            ph      <= ph_n;
            shreg   <= shreg_n;
            rw_q    <= rw_q_n;
            rx      <= rx_n;
            rdata_q <= rdata_n;
            ncs     <= ncs_n;
            sclk    <= sclk_n;
            copi    <= copi_n;
            done_q  <= done_n;
            cipo_m  <= cipo;
            cipo_s  <= cipo_m;
        end
    end
endmodule
